// File: rtl/alu_issue.sv
// alu_issue: ID/EX operand-issue stage in front of the 64-bit combinational ALU.
// Accepts decoded instructions on a valid/ready handshake, resolves RAW hazards
// and registers the selected operands that drive the ALU inputs directly.
// Build option: define ALU_ISSUE_FWD_EN to enable EX/MEM/WB forwarding; when it
// is undefined, operands come from the register file and any RAW match stalls.
module alu_issue #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [3:0]      id_alu_op,
  input  logic            id_is_32bit,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_wen,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_wen,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_op,
  output logic            ex_is_32bit,
  output logic [XLEN-1:0] ex_alu_A,
  output logic [XLEN-1:0] ex_alu_B,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_wen,
  output logic            ex_is_load
);

  logic            free;
  logic            capture;
  logic            hazard;
  logic            rs2_used;
  logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Source-match detection; x0 never matches any producer.
  always_comb begin
    rs2_used = !id_use_imm || (!id_wen && !id_is_load);
    ex_hit1  = ex_valid && ex_wen && (ex_rd == id_rs1) && (id_rs1 != '0);
    ex_hit2  = ex_valid && ex_wen && (ex_rd == id_rs2) && (id_rs2 != '0);
    mem_hit1 = mem_wen && (mem_rd == id_rs1) && (id_rs1 != '0);
    mem_hit2 = mem_wen && (mem_rd == id_rs2) && (id_rs2 != '0);
    wb_hit1  = wb_wen && (wb_rd == id_rs1) && (id_rs1 != '0);
    wb_hit2  = wb_wen && (wb_rd == id_rs2) && (id_rs2 != '0);
  end

`ifdef ALU_ISSUE_FWD_EN
  // Forwarding muxes (EX > MEM > WB > regfile); only load-use stalls.
  always_comb begin
    hazard  = ex_is_load && (ex_hit1 || (rs2_used && ex_hit2));
    rs1_val = id_rs1_data;
    if (ex_hit1 && !ex_is_load) rs1_val = alu_result;
    else if (mem_hit1)          rs1_val = mem_data;
    else if (wb_hit1)           rs1_val = wb_data;
    rs2_val = id_rs2_data;
    if (ex_hit2 && !ex_is_load) rs2_val = alu_result;
    else if (mem_hit2)          rs2_val = mem_data;
    else if (wb_hit2)           rs2_val = wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{alu_result, mem_data, wb_data};

  // No forwarding: any in-flight writer of a used source stalls until written back.
  always_comb begin
    hazard  = (ex_hit1 || mem_hit1 || wb_hit1) ||
              (rs2_used && (ex_hit2 || mem_hit2 || wb_hit2));
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
  end
`endif

  // Handshake: accept only into a free slot, free of hazards and not flushing.
  always_comb begin
    free     = !ex_valid || ex_ready;
    id_ready = free && !hazard && !flush;
    capture  = id_valid && id_ready;
  end

  // EX slot register: reset > flush > capture > drain; fields hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_alu_op   <= '0;
      ex_is_32bit <= 1'b0;
      ex_alu_A    <= '0;
      ex_alu_B    <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_wen      <= 1'b0;
      ex_is_load  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid    <= 1'b1;
      ex_alu_op   <= id_alu_op;
      ex_is_32bit <= id_is_32bit;
      ex_alu_A    <= rs1_val;
      ex_alu_B    <= id_use_imm ? id_imm : rs2_val;
      ex_rs2_data <= rs2_val;
      ex_rd       <= id_rd;
      ex_wen      <= id_wen;
      ex_is_load  <= id_is_load;
    end else if (free) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
